// File: rtl/vend_pkg.sv
// vend_pkg: shared requester IDs and arbiter state type for the vending RAM port
package vend_pkg;
    localparam int NUM_REQ = 3;
    localparam int VEND    = 0;
    localparam int PAY     = 1;
    localparam int AUDIT   = 2;
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, LOCKED} arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, searching from last_grant+1 with wrap
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx
);
    int c;
    always_comb begin
        win_oh  = '0;
        win_idx = last_grant;
        c       = 0;
        // scan farthest-first so the nearest pending requester is assigned last
        for (int k = N; k >= 1; k--) begin
            c = int'(last_grant) + k;
            c = c >= N ? c - N : c;
            if (req[c]) begin
                win_oh  = N'(1) << c;
                win_idx = IW'(c);
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one RAM port among requesters, with atomic lock hold
module ram_port_arbiter
    import vend_pkg::*;
#(
    parameter int NUM_REQ    = vend_pkg::NUM_REQ,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 15
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_data,
    output logic                          ram_we,
    input  logic [DATA_WIDTH-1:0]         ram_q,
    output logic                          busy,
    output logic                          lock_err,
    output logic [15:0]                   contention_cnt
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         last_q, last_d, win_q, win_d, pick_idx, cap_idx;
    logic                  we_q, we_d, cap, multi, lock_win, err;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         lock_cnt_q, lock_cnt_d, cnt_inc;
    logic [15:0]           cont_q, cont_d;
    logic [NUM_REQ-1:0]    ign_q, ign_d, pick_oh, win_oh;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req       (req),
        .last_grant(last_q),
        .win_oh    (pick_oh),
        .win_idx   (pick_idx)
    );

    assign win_oh   = NUM_REQ'(1) << win_q;
    // a forcibly released requester stays unlocked until it drops its lock input
    assign lock_win = lock[win_q] & ~ign_q[win_q];
    assign multi    = |(req & (req - NUM_REQ'(1)));
    assign cnt_inc  = lock_cnt_q + CW'(1);
    assign cap_idx  = state_q == LOCKED ? win_q : pick_idx;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        lock_cnt_d = lock_cnt_q;
        cont_d     = cont_q;
        ign_d      = ign_q & lock;
        cap        = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                cont_d = multi && cont_q != 16'hFFFF ? cont_q + 16'd1 : cont_q;
                if (|pick_oh) begin
                    cap        = 1'b1;
                    win_d      = pick_idx;
                    lock_cnt_d = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                last_d  = win_q;
                state_d = !we_q ? RDATA : lock_win ? LOCKED : IDLE;
            end
            RDATA: state_d = lock_win ? LOCKED : IDLE;
            LOCKED: begin
                lock_cnt_d = cnt_inc;
                if (!lock_win) state_d = IDLE;
                else if (cnt_inc == CW'(LOCK_MAX)) begin
                    err     = 1'b1;
                    ign_d   = ign_d | win_oh;
                    state_d = IDLE;
                end else if (req[win_q]) begin
                    cap     = 1'b1;
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            we_d   = we[cap_idx];
            addr_d = addr[cap_idx*ADDR_WIDTH +: ADDR_WIDTH];
            data_d = wdata[cap_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= IW'(NUM_REQ - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            lock_cnt_q <= '0;
            cont_q     <= '0;
            ign_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            lock_cnt_q <= lock_cnt_d;
            cont_q     <= cont_d;
            ign_q      <= ign_d;
        end
    end

    // strobes are gated by rst so a reset in ACCESS/RDATA kills the write or read-valid at once
    assign gnt            = state_q == ACCESS && !rst ? win_oh : '0;
    assign rvalid         = state_q == RDATA && !rst ? win_oh : '0;
    assign ram_we         = state_q == ACCESS && we_q && !rst;
    assign busy           = state_q != IDLE && !rst;
    assign lock_err       = err && !rst;
    assign ram_addr       = addr_q;
    assign ram_data       = data_q;
    assign rdata          = ram_q;
    assign contention_cnt = cont_q;
endmodule
